// File: rtl/mips_pkg.sv
// Shared encodings for the MEM stage: data-memory FSM states and access classification.
package mips_pkg;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } dmem_state_e;

    typedef enum logic [1:0] {
        ACC_NONE       = 2'd0,
        ACC_LOAD       = 2'd1,
        ACC_STORE      = 2'd2,
        ACC_MISALIGNED = 2'd3
    } acc_type_e;

    localparam int DMEM_CNT_W = 8;

    // A read+write combination is treated as a store.
    function automatic acc_type_e classify_access(input logic       mem_read,
                                                  input logic       mem_write,
                                                  input logic [1:0] addr_lo);
        acc_type_e acc;
        acc = ACC_LOAD;
        if (!(mem_read || mem_write)) begin
            acc = ACC_NONE;
        end else if (addr_lo != 2'b00) begin
            acc = ACC_MISALIGNED;
        end else if (mem_write) begin
            acc = ACC_STORE;
        end
        return acc;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_fsm.sv
// Data-memory handshake FSM with WAIT-cycle timeout and sticky bus-error flag.
// state | meaning
// IDLE  | no access outstanding, or access issued and acked in its first cycle
// WAIT  | request outstanding, counting cycles until ack or timeout
module dmem_fsm
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_access,
    input  logic i_ack,
    output logic o_req,
    output logic o_timeout,
    output logic o_bus_error
);

    localparam logic [DMEM_CNT_W-1:0] TIMEOUT_LIM = DMEM_CNT_W'(TIMEOUT_CYCLES);

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  bus_err_q, bus_err_d;

    assign o_timeout   = (state_q == DMEM_WAIT) && (cnt_q == TIMEOUT_LIM);
    assign o_req       = i_access & ~o_timeout;
    assign o_bus_error = bus_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        case (state_q)
            DMEM_IDLE: begin
                if (o_req && !i_ack) begin
                    state_d = DMEM_WAIT;
                    cnt_d   = DMEM_CNT_W'(1);
                end
            end
            DMEM_WAIT: begin
                if (o_timeout) begin
                    state_d   = DMEM_IDLE;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                end else if (i_ack || !i_access) begin
                    state_d = DMEM_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DMEM_CNT_W'(1);
                end
            end
            default: begin
                state_d = DMEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DMEM_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM and MEM/WB pipeline registers around a stalling data-memory port.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_read_data_2,
    input  logic [4:0]  i_write_register,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_mem_to_reg,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic [31:0] o_alu_result,
    output logic [31:0] o_read_data,
    output logic [4:0]  o_write_register,
    output logic        o_reg_write,
    output logic        o_mem_to_reg,
    output logic [31:0] o_fwd_value,
    output logic [4:0]  o_fwd_reg,
    output logic        o_fwd_valid,
    output logic        o_misaligned,
    output logic        o_bus_error
);

    logic [31:0] ex_alu_q, ex_alu_d;
    logic [31:0] ex_rd2_q, ex_rd2_d;
    logic [4:0]  ex_wr_q, ex_wr_d;
    logic        ex_rw_q, ex_rw_d;
    logic        ex_mr_q, ex_mr_d;
    logic        ex_mw_q, ex_mw_d;
    logic        ex_m2r_q, ex_m2r_d;

    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [4:0]  wb_wr_q, wb_wr_d;
    logic        wb_rw_q, wb_rw_d;
    logic        wb_m2r_q, wb_m2r_d;

    acc_type_e acc;
    logic      access_valid;
    logic      timeout;

    assign acc          = classify_access(ex_mr_q, ex_mw_q, ex_alu_q[1:0]);
    assign access_valid = (acc == ACC_LOAD) || (acc == ACC_STORE);

    dmem_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_dmem_fsm (
        .clk        (clk),
        .reset      (reset),
        .i_access   (access_valid),
        .i_ack      (i_dmem_ack),
        .o_req      (o_dmem_req),
        .o_timeout  (timeout),
        .o_bus_error(o_bus_error)
    );

    assign o_stall      = o_dmem_req & ~i_dmem_ack;
    assign o_dmem_we    = ex_mw_q;
    assign o_dmem_addr  = ex_alu_q;
    assign o_dmem_wdata = ex_rd2_q;
    assign o_misaligned = (acc == ACC_MISALIGNED);

    assign o_fwd_valid = ex_rw_q & ~ex_m2r_q & (ex_wr_q != 5'd0);
    assign o_fwd_value = ex_alu_q;
    assign o_fwd_reg   = ex_wr_q;

    always_comb begin
        ex_alu_d = ex_alu_q;
        ex_rd2_d = ex_rd2_q;
        ex_wr_d  = ex_wr_q;
        ex_rw_d  = ex_rw_q;
        ex_mr_d  = ex_mr_q;
        ex_mw_d  = ex_mw_q;
        ex_m2r_d = ex_m2r_q;
        if (!o_stall) begin
            ex_alu_d = i_alu_result;
            ex_rd2_d = i_read_data_2;
            ex_wr_d  = i_write_register;
            ex_rw_d  = i_reg_write;
            ex_mr_d  = i_mem_read;
            ex_mw_d  = i_mem_write;
            ex_m2r_d = i_mem_to_reg;
        end
    end

    // Stall cycles, misaligned accesses and aborted accesses all retire as all-zero bubbles.
    always_comb begin
        wb_alu_d   = '0;
        wb_rdata_d = '0;
        wb_wr_d    = '0;
        wb_rw_d    = 1'b0;
        wb_m2r_d   = 1'b0;
        if (!o_stall && (acc != ACC_MISALIGNED) && !timeout) begin
            wb_alu_d   = ex_alu_q;
            wb_rdata_d = (acc == ACC_LOAD) ? i_dmem_rdata : 32'd0;
            wb_wr_d    = ex_wr_q;
            wb_rw_d    = ex_rw_q & (acc != ACC_STORE);
            wb_m2r_d   = ex_m2r_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_alu_q   <= '0;
            ex_rd2_q   <= '0;
            ex_wr_q    <= '0;
            ex_rw_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
            ex_mw_q    <= 1'b0;
            ex_m2r_q   <= 1'b0;
            wb_alu_q   <= '0;
            wb_rdata_q <= '0;
            wb_wr_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_m2r_q   <= 1'b0;
        end else begin
            ex_alu_q   <= ex_alu_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_wr_q    <= ex_wr_d;
            ex_rw_q    <= ex_rw_d;
            ex_mr_q    <= ex_mr_d;
            ex_mw_q    <= ex_mw_d;
            ex_m2r_q   <= ex_m2r_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            wb_wr_q    <= wb_wr_d;
            wb_rw_q    <= wb_rw_d;
            wb_m2r_q   <= wb_m2r_d;
        end
    end

    assign o_alu_result     = wb_alu_q;
    assign o_read_data      = wb_rdata_q;
    assign o_write_register = wb_wr_q;
    assign o_reg_write      = wb_rw_q;
    assign o_mem_to_reg     = wb_m2r_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of WAIT cycles before a data-memory access is aborted (legal range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_alu_result  in  32  EX result; memory address or writeback value.
REQ-005 i_read_data_2  in  32  forwarded rt value; store data.
REQ-006 i_write_register  in  5  destination register.
REQ-007 i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1 each  EX control bits.
REQ-008 o_dmem_req  out  1  data-memory request.
REQ-009 o_dmem_we  out  1  1=store, 0=load.
REQ-010 o_dmem_addr  out  32  word-aligned byte address.
REQ-011 o_dmem_wdata  out  32  store data.
REQ-012 i_dmem_ack  in  1  access complete; rdata valid this cycle.
REQ-013 i_dmem_rdata  in  32  load data.
REQ-014 o_stall  out  1  freezes PC/IF/ID/EX upstream.
REQ-015 o_alu_result, o_read_data  out  32 each  MEM/WB register values.
REQ-016 o_write_register  out  5; o_reg_write, o_mem_to_reg  out  1 each  MEM/WB register controls.
REQ-017 o_fwd_value  out  32; o_fwd_reg  out  5; o_fwd_valid  out  1  EX/MEM-stage forwarding source.
REQ-018 o_misaligned  out  1  one-cycle pulse per faulting access.
REQ-019 o_bus_error  out  1  sticky timeout flag.

Function
REQ-020 Internal EX/MEM register SHALL capture all EX inputs on each edge where o_stall=0 and hold them while o_stall=1.
REQ-021 Access valid = latched (mem_read|mem_write) and alu_result[1:0]==2'b00; both read and write set SHALL be treated as a store.
REQ-022 Latched mem op with alu_result[1:0]!=0 SHALL issue no request, pulse o_misaligned for one cycle, and write a bubble (reg_write=0) into MEM/WB.
REQ-023 FSM states: IDLE, WAIT. IDLE->WAIT when o_dmem_req=1 and i_dmem_ack=0; WAIT->IDLE on ack or timeout.
REQ-024 o_dmem_req SHALL be combinational: 1 while an access is valid and not yet acked or aborted; addr=latched alu_result, wdata=latched read_data_2, we=latched mem_write.
REQ-025 o_stall = o_dmem_req & ~i_dmem_ack; zero-wait ack (same cycle as req) SHALL cause no stall.
REQ-026 A WAIT cycle counter SHALL start at 1 on IDLE->WAIT; when it reaches TIMEOUT_CYCLES without ack, the block SHALL drop req, set o_bus_error, release stall, and write a bubble into MEM/WB.
REQ-027 MEM/WB register SHALL load when o_stall=0: alu_result, read_data=i_dmem_rdata for loads (else 0), write_register, reg_write, mem_to_reg; while o_stall=1 it SHALL load a bubble (reg_write=0).
REQ-028 Latency: non-memory instruction reaches MEM/WB outputs 2 edges after EX presents it; load/store adds one cycle per wait cycle.
REQ-029 o_fwd_valid = latched reg_write & ~latched mem_to_reg & (write_register!=0); o_fwd_value = latched alu_result; o_fwd_reg = latched write_register.
REQ-030 Stores SHALL never assert MEM/WB reg_write regardless of i_reg_write.
REQ-031 i_dmem_ack while o_dmem_req=0 SHALL be ignored.

Reset
REQ-032 Reset SHALL force FSM to IDLE, counter 0, EX/MEM and MEM/WB registers to 0, o_bus_error 0, o_misaligned 0; req/stall therefore 0.
REQ-033 Reset asserted in WAIT SHALL abort the access immediately; no writeback occurs.

Structure
REQ-034 FSM state encodings and the access-type constants SHALL be added to mips_pkg.vh.
REQ-035 The block SHALL instantiate one sub-module, dmem_fsm, holding the FSM, timeout counter, and bus-error flag.

Verification
REQ-036 ADD result 0x0000_0010 to r5, no mem -> MEM/WB o_alu_result=0x10, reg=5, reg_write=1 after 2 edges; o_fwd_valid=1 in between.
REQ-037 Load addr 0x100, ack same cycle, rdata 0xDEAD_BEEF -> no stall; o_read_data=0xDEADBEEF, mem_to_reg=1.
REQ-038 Store addr 0x104, data 0x1234, ack after 3 cycles -> stall high 3 cycles, we=1, MEM/WB reg_write=0.
REQ-039 Load addr 0x102 -> no req, o_misaligned one-cycle pulse, bubble in MEM/WB.
REQ-040 Load with no ack, TIMEOUT_CYCLES=16 -> stall 16 cycles, then req drops, o_bus_error=1 until reset.
REQ-041 Reset asserted in WAIT -> req, stall, and all outputs 0 immediately; next instruction proceeds normally.
